// File: rtl/serial_uart_pkg.sv
// Shared types and constants for the serial MMIO <-> UART bridge.
package serial_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic int baud_cnt_width(input int clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
module uart_tx_fifo
   import serial_uart_pkg::*;
#(
   parameter int AW = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_push,
   input  logic [UART_DATA_BITS-1:0] i_data,
   input  logic                      i_pop,
   output logic [UART_DATA_BITS-1:0] o_data,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int DEPTH = 1 << AW;

   logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW-1:0]             r_wr_ptr;
   logic [AW-1:0]             r_rd_ptr;
   logic [AW:0]               r_count;
   logic                      w_push_ok;
   logic                      w_pop_ok;

   // Count saturates at DEPTH, so its MSB is exactly the full flag.
   assign o_full    = r_count[AW];
   assign o_empty   = (r_count == '0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/serial_uart_bridge.sv
// Serial MMIO byte endpoint: TX FIFO + 8N1 transmitter, 8N1 receiver with one-byte holding register.
//   state    | meaning
//   IDLE     | line idle / waiting for a byte or a start edge
//   START    | start bit (TX drives 0; RX confirms at mid-bit)
//   DATA     | 8 data bits, LSB first
//   STOP     | stop bit (TX drives 1; RX samples and delivers)
module serial_uart_bridge
   import serial_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int TX_FIFO_AW   = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] tx_data_in,
   input  logic                      tx_wren_in,
   output logic                      tx_ready_out,
   output logic [UART_DATA_BITS-1:0] rx_data_out,
   output logic                      rx_valid_out,
   input  logic                      rx_rden_in,
   output logic                      uart_txd_out,
   input  logic                      uart_rxd_in,
   output logic                      rx_overrun_out,
   output logic                      rx_frame_err_out
);

   localparam int                BAUD_W    = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

   tx_state_t                 r_tx_state;
   logic [BAUD_W-1:0]         r_tx_cnt;
   logic [2:0]                r_tx_bit;
   logic [UART_DATA_BITS-1:0] r_tx_shift;
   logic                      r_txd;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
   logic                      w_tx_pop;
   logic [UART_DATA_BITS-1:0] w_fifo_rdata;

   rx_state_t                 r_rx_state;
   logic [BAUD_W-1:0]         r_rx_cnt;
   logic [2:0]                r_rx_bit;
   logic [UART_DATA_BITS-1:0] r_rx_shift;
   logic                      r_rx_meta;
   logic                      r_rx_sync;
   logic [UART_DATA_BITS-1:0] r_rx_data;
   logic                      r_rx_valid;
   logic                      r_rx_overrun;
   logic                      r_rx_frame_err;
   logic                      w_rx_stop_sample;

   assign w_tx_pop = !w_fifo_empty &&
                     ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && (r_tx_cnt == '0)));

   uart_tx_fifo #(.AW(TX_FIFO_AW)) u_tx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (tx_wren_in),
      .i_data  (tx_data_in),
      .i_pop   (w_tx_pop),
      .o_data  (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // txd is registered from the current state, so the line trails the FSM by one cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_txd <= (r_tx_state == TX_DATA) ? r_tx_shift[0] : (r_tx_state != TX_START);
         case (r_tx_state)
            TX_IDLE: if (!w_fifo_empty) begin
               r_tx_shift <= w_fifo_rdata;
               r_tx_cnt   <= BIT_LAST;
               r_tx_state <= TX_START;
            end
            TX_START: if (r_tx_cnt == '0) begin
               r_tx_cnt   <= BIT_LAST;
               r_tx_bit   <= '0;
               r_tx_state <= TX_DATA;
            end else r_tx_cnt <= r_tx_cnt - 1'b1;
            TX_DATA: if (r_tx_cnt == '0) begin
               r_tx_cnt   <= BIT_LAST;
               r_tx_shift <= r_tx_shift >> 1;
               if (r_tx_bit == LAST_BIT) r_tx_state <= TX_STOP;
               else                      r_tx_bit   <= r_tx_bit + 1'b1;
            end else r_tx_cnt <= r_tx_cnt - 1'b1;
            TX_STOP: if (r_tx_cnt == '0) begin
               if (!w_fifo_empty) begin
                  r_tx_shift <= w_fifo_rdata;
                  r_tx_cnt   <= BIT_LAST;
                  r_tx_state <= TX_START;
               end else r_tx_state <= TX_IDLE;
            end else r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_meta <= uart_rxd_in;
         r_rx_sync <= r_rx_meta;
         case (r_rx_state)
            RX_IDLE: if (!r_rx_sync) begin
               r_rx_cnt   <= HALF_LAST;
               r_rx_state <= RX_START;
            end
            RX_START: if (r_rx_cnt == '0) begin
               if (r_rx_sync) r_rx_state <= RX_IDLE;
               else begin
                  r_rx_cnt   <= BIT_LAST;
                  r_rx_bit   <= '0;
                  r_rx_state <= RX_DATA;
               end
            end else r_rx_cnt <= r_rx_cnt - 1'b1;
            RX_DATA: if (r_rx_cnt == '0) begin
               r_rx_shift <= {r_rx_sync, r_rx_shift[UART_DATA_BITS-1:1]};
               r_rx_cnt   <= BIT_LAST;
               if (r_rx_bit == LAST_BIT) r_rx_state <= RX_STOP;
               else                      r_rx_bit   <= r_rx_bit + 1'b1;
            end else r_rx_cnt <= r_rx_cnt - 1'b1;
            RX_STOP: if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                     else                r_rx_cnt   <= r_rx_cnt - 1'b1;
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   assign w_rx_stop_sample = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);

   // A pop in the delivery cycle frees the holding register for the new byte.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rx_overrun   <= 1'b0;
         r_rx_frame_err <= 1'b0;
      end else begin
         r_rx_frame_err <= w_rx_stop_sample && !r_rx_sync;
         if (w_rx_stop_sample && r_rx_sync) begin
            if (!r_rx_valid || rx_rden_in) begin
               r_rx_data  <= r_rx_shift;
               r_rx_valid <= 1'b1;
            end else r_rx_overrun <= 1'b1;
         end else if (rx_rden_in) r_rx_valid <= 1'b0;
      end
   end

   assign tx_ready_out     = !w_fifo_full;
   assign uart_txd_out     = r_txd;
   assign rx_data_out      = r_rx_data;
   assign rx_valid_out     = r_rx_valid;
   assign rx_overrun_out   = r_rx_overrun;
   assign rx_frame_err_out = r_rx_frame_err;

endmodule
